// File: rtl/block_sched_if.sv
// Bundle of requester-side handshake, node-side drive/sample and response signals.
// Pure wiring: no state, no latency.
// Backpressure is carried by req_ready (one-hot accept) and node_rdy (node gating).
interface block_sched_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  // Requester side
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_data;
  logic [N-1:0]    req_ready;

  // Node side
  logic [3:0]      node_in1;
  logic [3:0]      node_in2;
  logic [3:0]      node_in3;
  logic [3:0]      node_in4;
  logic [3:0]      node_out;
  logic            node_rdy;

  // Response side
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic [3:0]      resp_data;
  logic            busy;

  // Environment view: requesters plus the node instance
  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  node_in1,
    input  node_in2,
    input  node_in3,
    input  node_in4,
    output node_out,
    output node_rdy,
    input  resp_valid,
    input  resp_id,
    input  resp_data,
    input  busy
  );

  // Scheduler view
  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output node_in1,
    output node_in2,
    output node_in3,
    output node_in4,
    input  node_out,
    input  node_rdy,
    output resp_valid,
    output resp_id,
    output resp_data,
    output busy
  );
endinterface

// File: rtl/block_sched.sv
// Round-robin scheduler sharing one LIF block node among N requesters; tags node output with requester ID.
// Latency: accept in cycle 0, response pulse in cycle HOLD+NODE_LAT+1; back-to-back period HOLD+NODE_LAT+1.
// Backpressure: accepts only in IDLE with node_rdy high; req_ready is a combinational one-hot grant.
module block_sched #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int HOLD     = 1,
  parameter int NODE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  block_sched_if.slave bus
);

  // Counter only ever holds HOLD-1 or NODE_LAT-1
  localparam int CNT_MAX = (HOLD > NODE_LAT) ? HOLD : NODE_LAT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDW:0]   N_W     = (IDW+1)'(N);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);
  localparam logic [CW-1:0]  HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0]  LAT_LD  = CW'(NODE_LAT - 1);

  // Elaboration-time parameter sanity
  if (N < 2 || N > 8) begin : g_bad_n
    $error("block_sched: N must be in 2..8");
  end
  if ((1 << IDW) < N) begin : g_bad_idw
    $error("block_sched: IDW too narrow for N");
  end
  if (HOLD < 1 || NODE_LAT < 1) begin : g_bad_lat
    $error("block_sched: HOLD and NODE_LAT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gid_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     node_in_q;
  logic            resp_valid_q;
  logic [IDW-1:0]  resp_id_q;
  logic [3:0]      resp_data_q;
  logic            busy_q;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW:0]    srch;
  logic [15:0]     gnt_dat;
  logic            accept;
  logic [IDW-1:0]  ptr_d;
  logic [N-1:0]    req_ready_d;

  // Round-robin search: first valid requester at or after ptr, wrapping within 0..N-1
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    srch    = '0;
    for (int k = 0; k < N; k++) begin
      srch = {1'b0, ptr_q} + (IDW+1)'(k);
      if (srch >= N_W) begin
        srch = srch - N_W;
      end
      if (!gnt_vld && bus.req_valid[srch[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = srch[IDW-1:0];
      end
    end
  end

  // Select the granted requester's 16-bit spike bundle
  always_comb begin
    gnt_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_dat = bus.req_data[16*i +: 16];
      end
    end
  end

  // Acceptance is gated by state, node readiness and reset; pointer advances past the winner
  always_comb begin
    accept = (state_q == S_IDLE) && bus.node_rdy && !rst && gnt_vld;
    ptr_d  = (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);
    req_ready_d = '0;
    for (int i = 0; i < N; i++) begin
      req_ready_d[i] = accept && (gnt_idx == IDW'(i));
    end
  end

  // Scheduler FSM: IDLE grants, LOAD drives the node, WAIT zeroes it and samples the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      gid_q        <= '0;
      cnt_q        <= '0;
      node_in_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            node_in_q <= gnt_dat;
            gid_q     <= gnt_idx;
            ptr_q     <= ptr_d;
            cnt_q     <= HOLD_LD;
            state_q   <= S_LOAD;
            busy_q    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cnt_q == '0) begin
            // Drop the inputs so the neuron integrates the bundle only once
            node_in_q <= '0;
            cnt_q     <= LAT_LD;
            state_q   <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            resp_data_q  <= bus.node_out;
            resp_id_q    <= gid_q;
            resp_valid_q <= 1'b1;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          node_in_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.node_in1   = node_in_q[3:0];
  assign bus.node_in2   = node_in_q[7:4];
  assign bus.node_in3   = node_in_q[11:8];
  assign bus.node_in4   = node_in_q[15:12];
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = busy_q;

  // At most one requester is granted, and only while idle
  a_rr_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));
  a_rr_idle:   assert property (@(posedge clk) (bus.req_ready != '0) |-> (state_q == S_IDLE));
  // Responses are single-cycle pulses
  a_resp_pulse: assert property (@(posedge clk) disable iff (rst) resp_valid_q |=> !resp_valid_q);

endmodule

// File: tb/tb_block_sched.sv
module tb_block_sched;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int HOLD_A [2] = '{1, 3};
  localparam int LAT_A  [2] = '{2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_data;
  logic            node_rdy;
  logic [3:0]      node_out;

  block_sched_if #(.N(N), .IDW(IDW)) bus0 ();
  block_sched_if #(.N(N), .IDW(IDW)) bus1 ();

  block_sched #(.N(N), .IDW(IDW), .HOLD(1), .NODE_LAT(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  block_sched #(.N(N), .IDW(IDW), .HOLD(3), .NODE_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  // Both instances see identical stimulus; withdrawal before accept is legal
  assign bus0.req_valid = req_valid;
  assign bus0.req_data  = req_data;
  assign bus0.node_rdy  = node_rdy;
  assign bus0.node_out  = node_out;
  assign bus1.req_valid = req_valid;
  assign bus1.req_data  = req_data;
  assign bus1.node_rdy  = node_rdy;
  assign bus1.node_out  = node_out;

  logic [N-1:0]   o_rr  [2];
  logic [15:0]    o_nin [2];
  logic           o_rv  [2];
  logic [IDW-1:0] o_rid [2];
  logic [3:0]     o_rd  [2];
  logic           o_bsy [2];

  assign o_rr[0]  = bus0.req_ready;
  assign o_nin[0] = {bus0.node_in4, bus0.node_in3, bus0.node_in2, bus0.node_in1};
  assign o_rv[0]  = bus0.resp_valid;
  assign o_rid[0] = bus0.resp_id;
  assign o_rd[0]  = bus0.resp_data;
  assign o_bsy[0] = bus0.busy;
  assign o_rr[1]  = bus1.req_ready;
  assign o_nin[1] = {bus1.node_in4, bus1.node_in3, bus1.node_in2, bus1.node_in1};
  assign o_rv[1]  = bus1.resp_valid;
  assign o_rid[1] = bus1.resp_id;
  assign o_rd[1]  = bus1.resp_data;
  assign o_bsy[1] = bus1.busy;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int m, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d got=%h expected=%h at %0t", nm, m, got, exp, $time);
  endtask

  // ---------------- behavioural model: one transaction record per instance ----------------
  bit          m_act [2];
  int          m_el  [2];   // cycles elapsed since the accept cycle
  int          m_gid [2];
  logic [15:0] m_gdat[2];
  int          m_ptr [2];
  bit          m_rv  [2];
  int          m_rid [2];
  logic [3:0]  m_rdat[2];
  int          mg;

  function automatic int exp_g(int m);
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr[m] + k) % N]) return (m_ptr[m] + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rr(int m);
    logic [N-1:0] r;
    int g;
    r = '0;
    if (rst || !node_rdy || m_act[m]) return r;
    g = exp_g(m);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] exp_nin(int m);
    if (m_act[m] && m_el[m] <= HOLD_A[m]) return m_gdat[m];
    return 16'h0;
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_act[m] = 0; m_el[m] = 0; m_gid[m] = 0; m_gdat[m] = '0;
      m_ptr[m] = 0; m_rv[m] = 0; m_rid[m] = 0; m_rdat[m] = '0;
    end
  end

  // Advance the model on each rising edge using the inputs of the cycle just ending
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_act[m] = 0; m_el[m] = 0; m_ptr[m] = 0;
        m_rv[m] = 0; m_rid[m] = 0; m_rdat[m] = '0;
      end else begin
        m_rv[m] = 0;
        if (m_act[m]) begin
          if (m_el[m] == HOLD_A[m] + LAT_A[m]) begin
            m_rdat[m] = node_out;
            m_rid[m]  = m_gid[m];
            m_rv[m]   = 1;
            m_act[m]  = 0;
          end else begin
            m_el[m] = m_el[m] + 1;
          end
        end else if (exp_rr(m) != '0) begin
          mg        = exp_g(m);
          m_act[m]  = 1;
          m_el[m]   = 1;
          m_gid[m]  = mg;
          m_gdat[m] = req_data[16*mg +: 16];
          m_ptr[m]  = (mg + 1) % N;
        end
      end
    end
  end

  // Compare every output of both instances against the model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        chk("m_req_ready",  m, 32'(o_rr[m]),  32'(exp_rr(m)));
        chk("m_node_in",    m, 32'(o_nin[m]), 32'(exp_nin(m)));
        chk("m_busy",       m, 32'(o_bsy[m]), 32'(m_act[m]));
        chk("m_resp_valid", m, 32'(o_rv[m]),  32'(m_rv[m]));
        chk("m_resp_id",    m, 32'(o_rid[m]), 32'(m_rid[m]));
        chk("m_resp_data",  m, 32'(o_rd[m]),  32'(m_rdat[m]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus with hand-computed expectations ----------------
  initial begin
    logic [3:0] e;
    rst = 1'b1; req_valid = '1; req_data = '0; node_rdy = 1'b1; node_out = '0;

    // Reset holds everything at zero and blocks acceptance
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("rst_rr",   m, 32'(o_rr[m]),  32'h0);
      chk("rst_nin",  m, 32'(o_nin[m]), 32'h0);
      chk("rst_busy", m, 32'(o_bsy[m]), 32'h0);
      chk("rst_rv",   m, 32'(o_rv[m]),  32'h0);
    end

    // Single request from requester 2, data {1,2,3,4}
    tick();
    rst = 1'b0; req_valid = 4'b0100; req_data = 64'h0000_1234_0000_0000;
    @(negedge clk);
    chk("single_rr", 0, 32'(o_rr[0]), 32'h4);
    chk("single_rr", 1, 32'(o_rr[1]), 32'h4);
    for (int c = 1; c <= 5; c++) begin
      tick();
      req_valid = '0;
      node_out  = (c >= 3) ? 4'hA : 4'h0;
      @(negedge clk);
      if (c == 1) begin
        chk("single_in1", 0, 32'(bus0.node_in1), 32'h4);
        chk("single_in4", 0, 32'(bus0.node_in4), 32'h1);
      end
      if (c == 2 || c == 3) chk("single_in_zero", 0, 32'(o_nin[0]), 32'h0);
      if (c <= 3) chk("sweep_in_data", 1, 32'(o_nin[1]), 32'h1234);
      if (c == 4) begin
        chk("single_rv",  0, 32'(o_rv[0]),  32'h1);
        chk("single_rid", 0, 32'(o_rid[0]), 32'h2);
        chk("single_rd",  0, 32'(o_rd[0]),  32'hA);
        chk("sweep_in_zero", 1, 32'(o_nin[1]), 32'h0);
        chk("sweep_rv_early", 1, 32'(o_rv[1]), 32'h0);
      end
      if (c == 5) begin
        chk("sweep_rv",  1, 32'(o_rv[1]),  32'h1);
        chk("sweep_rid", 1, 32'(o_rid[1]), 32'h2);
        chk("sweep_rd",  1, 32'(o_rd[1]),  32'hA);
        chk("single_rv_fall", 0, 32'(o_rv[0]), 32'h0);
      end
    end
    node_out = '0;

    // Start a transaction for requester 1, then reset in its cycle 2
    tick();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("abort_rr", 0, 32'(o_rr[0]), 32'h2);
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1; req_valid = '1;
    @(negedge clk);
    chk("abort_rr_rst", 0, 32'(o_rr[0]), 32'h0);
    chk("abort_rr_rst", 1, 32'(o_rr[1]), 32'h0);

    // Contention from reset, then fairness skip with only 0 and 3 valid
    for (int c = 0; c <= 25; c++) begin
      tick();
      rst = 1'b0;
      node_out = 4'($urandom);
      if (c <= 16)      req_valid = 4'b1111;
      else if (c <= 20) req_valid = 4'b1001;
      else if (c <= 24) req_valid = 4'b0001;
      else              req_valid = 4'b0000;
      @(negedge clk);
      if (c == 0) begin
        for (int m = 0; m < 2; m++) begin
          chk("abort_nin",  m, 32'(o_nin[m]), 32'h0);
          chk("abort_busy", m, 32'(o_bsy[m]), 32'h0);
          chk("abort_rv",   m, 32'(o_rv[m]),  32'h0);
          chk("abort_rid",  m, 32'(o_rid[m]), 32'h0);
          chk("abort_rd",   m, 32'(o_rd[m]),  32'h0);
        end
      end
      if (c >= 1 && c <= 3) chk("abort_no_resp", 0, 32'(o_rv[0]), 32'h0);
      if (c <= 16) begin
        e = '0;
        if (c % 4 == 0) e[(c / 4) % 4] = 1'b1;
        chk("contend_rr", 0, 32'(o_rr[0]), 32'(e));
      end
      if (c == 4 || c == 8 || c == 12 || c == 16) begin
        chk("contend_rv",  0, 32'(o_rv[0]),  32'h1);
        chk("contend_rid", 0, 32'(o_rid[0]), 32'(c / 4 - 1));
      end
      if (c == 20) chk("fair_skip_rr", 0, 32'(o_rr[0]), 32'h8);
      if (c == 24) chk("fair_wrap_rr", 0, 32'(o_rr[0]), 32'h1);
    end

    // Drain, then hold node_rdy low with requester 1 waiting
    repeat (8) tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      node_rdy = 1'b0; req_valid = 4'b0010; req_data = {$urandom, $urandom};
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk("gate_rr",   m, 32'(o_rr[m]),  32'h0);
        chk("gate_busy", m, 32'(o_bsy[m]), 32'h0);
      end
    end
    tick();
    node_rdy = 1'b1;
    @(negedge clk);
    chk("gate_release_rr", 0, 32'(o_rr[0]), 32'h2);
    chk("gate_release_rr", 1, 32'(o_rr[1]), 32'h2);

    // Randomized traffic, readiness drops and occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst      = ($urandom_range(0, 199) == 0);
      node_rdy = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) req_valid = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_data = {$urandom, $urandom};
      node_out = 4'($urandom);
    end
    tick();
    rst = 1'b0; req_valid = '0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/block_sched.md
# block_sched

Round-robin scheduler that shares one LIF `block` node among N requesters. Each requester presents a bundle of four 4-bit spike inputs. The scheduler grants one request at a time, drives the node inputs for a fixed window, then zeroes them so the neuron does not re-integrate. After a fixed node latency it samples the node output and returns it tagged with the requester ID. It sits between the IO fabric and a single `block` instance.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8)
- `IDW`, 2, width of requester ID; must satisfy 2^IDW >= N
- `HOLD`, 1, cycles the node inputs carry request data (>=1)
- `NODE_LAT`, 2, cycles from end of HOLD to a valid `node_out` (>=1)

Ports:
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N  request pending, one bit per requester
- `req_data`  in  16*N  requester i at [16i+15:16i], packed {in4,in3,in2,in1}
- `req_ready`  out  N  one-hot accept; transfer when `req_valid[i] & req_ready[i]`
- `node_in1`..`node_in4`  out  4 each  to block `in1`..`in4`
- `node_out`  in  4  from block `out`
- `node_rdy`  in  1  from block `rdy`; gates acceptance only
- `resp_valid`  out  1  one-cycle pulse, response valid
- `resp_id`  out  IDW  requester index of the response
- `resp_data`  out  4  sampled node output
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, LOAD, WAIT. `busy` is high in LOAD and WAIT.
- IDLE:
  - If `node_rdy` is high and any `req_valid` bit is set, grant index g = first set bit at or after `ptr`, searching upward modulo N.
  - `req_ready[g]` is combinational and high in this same cycle. All other `req_ready` bits are 0.
  - On the edge: capture `req_data[g]` into the node input registers, store g, set `ptr` to (g+1) mod N, load the counter with HOLD-1, and go to LOAD.
- LOAD: `node_in*` = captured data. Count down; at 0, zero `node_in*`, load the counter with NODE_LAT-1, and go to WAIT.
- WAIT: `node_in*` = 0. Count down; at 0, register `resp_data` from `node_out`, set `resp_id` = g and `resp_valid` = 1, and go to IDLE.
- `resp_valid` falls after one cycle. `resp_data` and `resp_id` hold until the next response.
- A new request can be accepted in the same cycle that `resp_valid` is high.
- `req_ready` is 0 in LOAD and WAIT, and whenever `node_rdy` is 0 or `rst` is 1.
- Requesters hold `req_valid`/`req_data` stable until accepted. If a requester withdraws before acceptance, the scheduler keeps no state for it.
- A `node_rdy` deassertion mid-transaction is ignored; the transaction completes.
- Requester indices >= N do not exist. The search covers only 0..N-1.

## Timing
- Accept in cycle 0.
- `node_in*` carry data in cycles 1..HOLD.
- `node_in*` are zero in cycles HOLD+1..HOLD+NODE_LAT.
- `node_out` is sampled at the end of cycle HOLD+NODE_LAT.
- `resp_valid` is high in cycle HOLD+NODE_LAT+1, with the FSM in IDLE.
- Defaults: response in cycle 4. Back-to-back period is HOLD+NODE_LAT+1 = 4 cycles.
- Reset values: `node_in*`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `busy`=0, `ptr`=0, state IDLE, `req_ready`=0.
- Reset in any state (including mid-LOAD/WAIT) takes effect next edge. The in-flight request is dropped with no response, and `node_in*` are zero from the next cycle.

## Test plan
- Single request, defaults: requester 2 valid with data {4'h1,4'h2,4'h3,4'h4} in cycle 0 while `node_rdy`=1. Required response:
  - `req_ready`=4'b0100 in cycle 0.
  - `node_in1`=4, `node_in4`=1 in cycle 1; all `node_in*` are 0 in cycles 2-3.
  - Model `node_out`=4'hA in cycle 3 gives `resp_valid`=1, `resp_id`=2, `resp_data`=4'hA in cycle 4.
- Contention: all four requesters valid from reset and held. Required grant order is 0,1,2,3,0, with accepts at cycles 0,4,8,12,16 and `resp_id` sequence 0,1,2,3 at cycles 4,8,12,16.
- Fairness skip: `ptr`=1 after a grant to 0, with only requesters 0 and 3 valid. Required: next grant is 3, then 0.
- Readiness gating: `node_rdy`=0 with requester 1 valid for 5 cycles. Required: `req_ready`=0 and `busy`=0 throughout; accept occurs in the first cycle `node_rdy`=1.
- Reset mid-operation: `rst`=1 in cycle 2 of a transaction. Required: no `resp_valid` ever for that request; all outputs 0 next cycle; `ptr`=0, so the next grant with all valid is requester 0.
- Parameter sweep: HOLD=3, NODE_LAT=1, single request. Required: `node_in*` nonzero in cycles 1-3, zero in cycle 4, `resp_valid` in cycle 5.
